// File: rtl/spi_seq.sv
// spi_seq -- upstream command sequencer for the spi bus-register block.
//
// Takes one transfer request (size + up to 32 bits of TX data) and walks the
// spi block through DATASIZE / DATA_IN / CTRL writes on the 34-bit ibus.
// It then polls STATUS for TxDone, reads DATA_OUT back (one or two words) and
// returns the result on a valid/ready response port.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   req_*           request handshake (ready only in IDLE), size, tx data
//   rsp_*           response handshake, rx data, timeout error flag
//   ibus            {clk, bwr, baddr[15:0], bwrdata[15:0]}
//   rd_data         spi readback (DATA_OUT or STATUS, selected by baddr)
//   busy            high whenever not IDLE
//
// Optional feature macro: SPI_SEQ_TIMEOUT_EN
//   When defined, WAIT_BUSY / WAIT_DONE give up after TIMEOUT_CYC cycles.
//   The sequencer then issues CTRL=RST, CTRL=CLEAR and answers with rsp_err=1.
//   When undefined, the waits are unbounded and rsp_err is constant 0.
module spi_seq #(
  parameter logic [15:0] BASE_ADDR   = 16'h2000,
  parameter int          HOLD_CYC    = 8,
  parameter int          TXDONE_BIT  = 12,
  parameter int          TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_size,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [33:0] ibus,
  input  logic [15:0] rd_data,
  output logic        busy
);

  localparam logic [15:0] A_CTRL = BASE_ADDR;          // CTRL / DATA_OUT
  localparam logic [15:0] A_SIZE = BASE_ADDR + 16'd1;
  localparam logic [15:0] A_DIN  = BASE_ADDR + 16'd2;
  localparam logic [15:0] A_STAT = BASE_ADDR + 16'd3;
  localparam logic [15:0] HOLD_N = (HOLD_CYC < 1) ? 16'd1 : 16'(HOLD_CYC);

  typedef enum logic [3:0] {
    S_IDLE, S_W_SIZE, S_W_LO, S_W_HI, S_C_WR, S_C_CLR, S_C_START, S_C_RD,
    S_C_RST, S_HOLD, S_WAIT_BUSY, S_WAIT_DONE, S_RSP
  } state_e;

  state_e      state_q, state_d;
  state_e      ret_q, ret_d;        // where HOLD goes when it expires
  logic        ph_q, ph_d;          // data writes: 0 = bwr pulse, 1 = idle gap
  logic [15:0] hold_q, hold_d;
  logic [5:0]  size_q, size_d;
  logic [31:0] data_q, data_d;
  logic        wide_q, wide_d;      // size >= 24: two 16-bit words each way
  logic        hi_sent_q, hi_sent_d;
  logic        rx_q, rx_d;          // START issued: C_CLR now leads to reads
  logic        cap_q, cap_d;        // current HOLD follows a READ command
  logic [1:0]  rd_cnt_q, rd_cnt_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        err_flag;

  logic        bwr;
  logic [15:0] baddr, bwrdata;
  logic        txdone, size_ok;

  assign txdone  = rd_data[TXDONE_BIT];
  assign size_ok = (req_size == 6'd8) || (req_size == 6'd16) ||
                   (req_size == 6'd24) || (req_size == 6'd32);

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  logic        err_q, err_d;
  logic [15:0] to_q, to_d;
  assign err_flag = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = |TIMEOUT_CYC;
  assign err_flag   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ret_q      <= S_IDLE;
      ph_q       <= 1'b0;
      hold_q     <= '0;
      size_q     <= '0;
      data_q     <= '0;
      wide_q     <= 1'b0;
      hi_sent_q  <= 1'b0;
      rx_q       <= 1'b0;
      cap_q      <= 1'b0;
      rd_cnt_q   <= '0;
      rsp_data_q <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
      err_q      <= 1'b0;
      to_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      ph_q       <= ph_d;
      hold_q     <= hold_d;
      size_q     <= size_d;
      data_q     <= data_d;
      wide_q     <= wide_d;
      hi_sent_q  <= hi_sent_d;
      rx_q       <= rx_d;
      cap_q      <= cap_d;
      rd_cnt_q   <= rd_cnt_d;
      rsp_data_q <= rsp_data_d;
`ifdef SPI_SEQ_TIMEOUT_EN
      err_q      <= err_d;
      to_q       <= to_d;
`endif
    end
  end

  // Next-state
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    ph_d       = 1'b0;
    hold_d     = hold_q;
    size_d     = size_q;
    data_d     = data_q;
    wide_d     = wide_q;
    hi_sent_d  = hi_sent_q;
    rx_d       = rx_q;
    cap_d      = cap_q;
    rd_cnt_d   = rd_cnt_q;
    rsp_data_d = rsp_data_q;
`ifdef SPI_SEQ_TIMEOUT_EN
    err_d      = err_q;
`endif
    case (state_q)
      S_IDLE: if (req_valid) begin
        state_d    = S_W_SIZE;
        size_d     = size_ok ? req_size : 6'd8;
        data_d     = req_data;
        wide_d     = size_ok && (req_size >= 6'd24);
        hi_sent_d  = 1'b0;
        rx_d       = 1'b0;
        cap_d      = 1'b0;
        rd_cnt_d   = '0;
        rsp_data_d = '0;
`ifdef SPI_SEQ_TIMEOUT_EN
        err_d      = 1'b0;
`endif
      end
      // Data writes take two cycles so consecutive bwr pulses never touch.
      S_W_SIZE: begin ph_d = ~ph_q; if (ph_q) state_d = S_W_LO; end
      S_W_LO:   begin ph_d = ~ph_q; if (ph_q) state_d = S_C_WR; end
      S_W_HI:   begin
        ph_d = ~ph_q;
        if (ph_q) begin state_d = S_C_WR; hi_sent_d = 1'b1; end
      end
      S_C_WR, S_C_RST: begin
        state_d = S_HOLD; ret_d = S_C_CLR; hold_d = HOLD_N;
      end
      S_C_RD: begin
        state_d = S_HOLD; ret_d = S_C_CLR; hold_d = HOLD_N; cap_d = 1'b1;
      end
      // CLEAR is the hinge of the sequence: what follows depends on progress.
      S_C_CLR: begin
        if (err_flag || rd_cnt_q == (wide_q ? 2'd2 : 2'd1)) begin
          state_d = S_RSP;
        end else begin
          state_d = S_HOLD;
          hold_d  = HOLD_N;
          if (rx_q)                       ret_d = S_C_RD;
          else if (wide_q && !hi_sent_q)  ret_d = S_W_HI;
          else                            ret_d = S_C_START;
        end
      end
      S_C_START:   begin state_d = S_WAIT_BUSY; rx_d = 1'b1; end
      S_WAIT_BUSY: if (txdone)  state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (!txdone) state_d = S_C_CLR;
      S_HOLD: begin
        if (hold_q <= 16'd1) begin
          state_d = ret_q;
          if (cap_q) begin
            if (rd_cnt_q == 2'd0) rsp_data_d[15:0]  = rd_data;
            else                  rsp_data_d[31:16] = rd_data;
            rd_cnt_d = rd_cnt_q + 2'd1;
          end
          cap_d = 1'b0;
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end
      S_RSP:   if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef SPI_SEQ_TIMEOUT_EN
    // Counter restarts on every entry into a wait state.
    if ((state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE) &&
        state_d == state_q && to_q == TO_LAST) begin
      state_d    = S_C_RST;
      err_d      = 1'b1;
      rsp_data_d = '0;
    end
    to_d = ((state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE) &&
            state_d == state_q) ? to_q + 16'd1 : 16'd0;
`endif
  end

  // Outputs
  always_comb begin
    bwr     = 1'b0;
    baddr   = '0;
    bwrdata = '0;
    case (state_q)
      S_W_SIZE:  begin bwr = ~ph_q; baddr = A_SIZE; bwrdata = {10'd0, size_q}; end
      S_W_LO:    begin bwr = ~ph_q; baddr = A_DIN;  bwrdata = data_q[15:0];    end
      S_W_HI:    begin bwr = ~ph_q; baddr = A_DIN;  bwrdata = data_q[31:16];   end
      S_C_WR:    begin bwr = 1'b1;  baddr = A_CTRL; bwrdata = 16'd1; end
      S_C_RD:    begin bwr = 1'b1;  baddr = A_CTRL; bwrdata = 16'd2; end
      S_C_START: begin bwr = 1'b1;  baddr = A_CTRL; bwrdata = 16'd3; end
      S_C_CLR:   begin bwr = 1'b1;  baddr = A_CTRL; bwrdata = 16'd4; end
      S_C_RST:   begin bwr = 1'b1;  baddr = A_CTRL; bwrdata = 16'd5; end
      S_HOLD:    baddr = A_CTRL;    // also DATA_OUT: read capture happens here
      S_WAIT_BUSY, S_WAIT_DONE: baddr = A_STAT;
      default: ;
    endcase
  end

  assign ibus      = {clk, bwr, baddr, bwrdata};
  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RSP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = err_flag;

endmodule

// File: tb/tb_spi_seq.sv
// Self-checking bench for spi_seq: a behavioural spi block model answers the
// bus writes, directed vectors plus random transfers are scored against
// expected write sequences and returned data.
module tb_spi_seq;
  localparam logic [15:0] BASE = 16'h2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, busy;
  logic [5:0]  req_size;
  logic [31:0] req_data, rsp_data;
  logic [33:0] ibus;
  logic [15:0] rd_data;

  spi_seq #(.BASE_ADDR(BASE), .HOLD_CYC(8), .TXDONE_BIT(12), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_size(req_size), .req_data(req_data), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ibus(ibus), .rd_data(rd_data), .busy(busy));

  always #5 clk = ~clk;

  wire        bwr_w   = ibus[32];
  wire [15:0] baddr_w = ibus[31:16];
  wire [15:0] wdat_w  = ibus[15:0];

  int checks = 0, errors = 0;

  // ---- spi block model ----
  logic [31:0] m_rx;
  int          m_d1, m_d2, rd_idx, c, b2b;
  bit          active, prev_bwr;
  logic [15:0] dout;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic        txd;

  initial begin
    active = 0; c = 0; b2b = 0; prev_bwr = 0; rd_idx = 0;
    m_d1 = 0; m_d2 = 1; m_rx = '0; dout = '0;
  end

  // TxDone is low for m_d1 cycles after START, high for m_d2, then low.
  assign txd = active && (c >= m_d1) && (c < m_d1 + m_d2);
  assign rd_data = (baddr_w == BASE + 16'd3) ? (16'h8001 | (16'(txd) << 12)) :
                   (baddr_w == BASE)         ? dout : 16'hDEAD;

  always @(negedge clk) begin
    if (active) c++;
    if (bwr_w) begin
      got_q.push_back({baddr_w, wdat_w});
      if (baddr_w == BASE && wdat_w == 16'd3) begin active = 1; c = -1; end
      if (baddr_w == BASE && wdat_w == 16'd2) begin
        dout = (rd_idx == 0) ? m_rx[15:0] : m_rx[31:16];
        rd_idx++;
      end
    end
    if (bwr_w && prev_bwr) b2b++;
    prev_bwr = bwr_w;
  end

  // ---- helpers ----
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] eff_size(input logic [5:0] s);
    return (s == 6'd8 || s == 6'd16 || s == 6'd24 || s == 6'd32) ? s : 6'd8;
  endfunction

  // Expected ibus write list for one transfer, straight from the command order.
  function automatic void build_exp(input logic [5:0] sz, input logic [31:0] d, input bit tmo);
    logic [5:0] e;
    bit wide;
    e = eff_size(sz);
    wide = (e >= 6'd24);
    exp_q.delete();
    exp_q.push_back({BASE + 16'd1, 10'd0, e});
    exp_q.push_back({BASE + 16'd2, d[15:0]});
    exp_q.push_back({BASE, 16'd1});
    exp_q.push_back({BASE, 16'd4});
    if (wide) begin
      exp_q.push_back({BASE + 16'd2, d[31:16]});
      exp_q.push_back({BASE, 16'd1});
      exp_q.push_back({BASE, 16'd4});
    end
    exp_q.push_back({BASE, 16'd3});
    if (tmo) begin
      exp_q.push_back({BASE, 16'd5});
      exp_q.push_back({BASE, 16'd4});
    end else begin
      exp_q.push_back({BASE, 16'd4});
      exp_q.push_back({BASE, 16'd2});
      exp_q.push_back({BASE, 16'd4});
      if (wide) begin
        exp_q.push_back({BASE, 16'd2});
        exp_q.push_back({BASE, 16'd4});
      end
    end
  endfunction

  task automatic chk_writes(input string nm);
    int bad;
    bad = -1;
    for (int i = 0; i < exp_q.size() && bad < 0; i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad = i;
    if (bad < 0 && got_q.size() != exp_q.size()) bad = exp_q.size();
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: write #%0d got %0h expected %0h (got %0d writes, expected %0d)",
               nm, bad, (bad < got_q.size()) ? got_q[bad] : 32'hX,
               (bad < exp_q.size()) ? exp_q[bad] : 32'hX, got_q.size(), exp_q.size());
    end
  endtask

  task automatic run_txn(input logic [5:0] sz, input logic [31:0] d, input logic [31:0] rx,
                         input int d1, input int d2, input int bp,
                         output logic [31:0] rdat, output logic rerr, output int lat);
    int n;
    @(negedge clk);
    m_rx = rx; m_d1 = d1; m_d2 = d2; rd_idx = 0; active = 0; got_q.delete();
    req_valid = 1; req_size = sz; req_data = d;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    chk("req_ready_idle", req_ready, 1);
    @(negedge clk);
    req_valid = 0; req_size = 6'($urandom); req_data = $urandom;
    lat = 1;
    chk("busy_after_accept", {busy, req_ready}, 2'b10);
    while (!rsp_valid && lat < 3000) begin @(negedge clk); lat++; end
    rdat = rsp_data; rerr = rsp_err;
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_wait: got no rsp_valid expected one within 3000 cycles");
      return;
    end
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_stable", {rsp_valid, req_ready, rsp_err, rsp_data}, {1'b1, 1'b0, rerr, rdat});
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("rsp_release", {rsp_valid, req_ready, busy}, 3'b010);
  endtask

  typedef struct {
    logic [5:0]  sz;
    logic [31:0] data;
    logic [31:0] rx;
    int          d1, d2, bp;
    logic [31:0] exp;
  } vec_t;

  vec_t        vec[6];
  logic [31:0] rdat;
  logic        rerr;
  int          lat;

  initial begin
    vec[0] = '{6'd8,  32'h0000_00A5, 32'h0000_003C, 0, 1, 0,  32'h0000_003C};
    vec[1] = '{6'd32, 32'h1234_5678, 32'hBEEF_1234, 1, 2, 0,  32'hBEEF_1234};
    vec[2] = '{6'd12, 32'hFFFF_1234, 32'h5555_00AA, 0, 1, 0,  32'h0000_00AA};
    vec[3] = '{6'd16, 32'h0000_C0DE, 32'h1111_2222, 3, 1, 0,  32'h0000_2222};
    vec[4] = '{6'd24, 32'h00AB_CDEF, 32'h0077_8899, 2, 2, 20, 32'h0077_8899};
    vec[5] = '{6'd0,  32'h0000_0001, 32'hFFFF_FFFF, 0, 2, 3,  32'h0000_FFFF};

    rst = 0; req_valid = 0; rsp_ready = 0; req_size = '0; req_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_bus", {ibus[32:0]}, 33'h0);
    chk("reset_ctl", {rsp_valid, rsp_err, req_ready, busy, rsp_data}, {4'b0010, 32'h0});
    chk("ibus_clk", ibus[33], clk);
    rst = 1;

    // directed table
    foreach (vec[i]) begin
      run_txn(vec[i].sz, vec[i].data, vec[i].rx, vec[i].d1, vec[i].d2, vec[i].bp, rdat, rerr, lat);
      chk($sformatf("vec%0d_data", i), rdat, vec[i].exp);
      chk($sformatf("vec%0d_err", i), rerr, 0);
      build_exp(vec[i].sz, vec[i].data, 0);
      chk_writes($sformatf("vec%0d_writes", i));
      if (eff_size(vec[i].sz) <= 6'd16 && vec[i].d1 == 0 && vec[i].d2 == 1)
        chk($sformatf("vec%0d_latency", i), lat, 45);
    end

    // reset in the middle of WAIT_DONE
    @(negedge clk);
    m_d1 = 2; m_d2 = 200; active = 0; rd_idx = 0;
    req_valid = 1; req_size = 6'd8; req_data = 32'h77;
    @(negedge clk);
    req_valid = 0;
    repeat (35) @(negedge clk);
    chk("mid_wait_status_addr", {busy, baddr_w}, {1'b1, BASE + 16'd3});
    rst = 0;
    #1;
    chk("rst_async", {bwr_w, busy, req_ready, rsp_valid}, 4'b0010);
    @(negedge clk);
    rst = 1;
    run_txn(6'd16, 32'h0000_BEAD, 32'h0000_F00D, 1, 1, 0, rdat, rerr, lat);
    chk("post_rst_data", rdat, 32'h0000_F00D);
    build_exp(6'd16, 32'h0000_BEAD, 0);
    chk_writes("post_rst_writes");

    // random transfers against the model
    for (int k = 0; k < 12; k++) begin
      logic [5:0]  sz;
      logic [31:0] d, rx, e;
      int          sel;
      sel = $urandom_range(0, 4);
      sz  = (sel == 4) ? 6'($urandom) : 6'(8 * (sel + 1));
      d   = $urandom;
      rx  = $urandom;
      e   = (eff_size(sz) >= 6'd24) ? rx : {16'h0, rx[15:0]};
      run_txn(sz, d, rx, $urandom_range(0, 5), $urandom_range(1, 5), $urandom_range(0, 3),
              rdat, rerr, lat);
      chk($sformatf("rnd%0d_data", k), rdat, e);
      build_exp(sz, d, 0);
      chk_writes($sformatf("rnd%0d_writes", k));
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    // TxDone never rises
    run_txn(6'd8, 32'h0000_0042, 32'h0000_1234, 1 << 20, 1, 2, rdat, rerr, lat);
    chk("tmo_err", rerr, 1);
    chk("tmo_data", rdat, 32'h0);
    build_exp(6'd8, 32'h0000_0042, 1);
    chk_writes("tmo_writes");
`endif

    chk("no_back_to_back_bwr", b2b, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_seq.md
Name: spi_seq

Overview:
- Upstream command sequencer for the spi bus-register block.
- Accepts one SPI transaction per valid/ready request (size, up to 32 bits of transmit data).
- Drives the 34-bit ibus with the write sequence the spi block needs: DATASIZE, DATA_IN, CTRL commands WRITE/CLEAR/START/READ.
- Polls the spi status word, reads the received word(s) back, and returns them on a valid/ready response port.

Parameters:
- BASE_ADDR, 16'h2000: spi block base. CTRL/DATA_OUT = +0, DATASIZE = +1, DATA_IN = +2, STATUS = +3.
- HOLD_CYC, 8: cycles CTRL address is held (bwr=0) after each command write, so the spi FSM can complete.
- TXDONE_BIT, 12: TxDone position in the status word.
- TIMEOUT_CYC, 4096: WAIT_BUSY/WAIT_DONE limit (only with SPI_SEQ_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; also driven onto ibus[33].
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_size  in  6  transfer bits: 8, 16, 24 or 32.
- req_data  in  32  transmit data, MSB first; [15:0] = lo word, [31:16] = hi word.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response accepted.
- rsp_data  out  32  received data; [31:16] = 0 when size < 24.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- ibus  out  34  {clk, bwr, baddr[15:0], bwrdata[15:0]}.
- rd_data  in  16  spi data/readback bus (DATA_OUT or STATUS, per baddr).
- busy  out  1  high when not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; bwr=0, baddr=0, bwrdata=0.
  - rsp_valid=0, rsp_data=0, rsp_err=0, req_ready=1, busy=0.
  - All counters cleared.
- Reset mid-transaction: abandon at once; the request is not replayed.
- Bus write: exactly one cycle with bwr=1, baddr/bwrdata valid. bwr=0 on the following cycle. Two bwr pulses never occur back-to-back.
- Handshake: request latched on req_valid && req_ready (IDLE only). Unsupported sizes (not 8/16/24/32) are coerced to 8.
- FSM:
  - IDLE -> W_SIZE: write DATASIZE = size.
  - W_SIZE -> W_LO: write DATA_IN = data[15:0].
  - W_LO -> C_WR: write CTRL = 1 (WRITE).
  - C_WR -> HOLD: baddr=CTRL, bwr=0 for HOLD_CYC cycles.
  - HOLD -> C_CLR: write CTRL = 4 (CLEAR), then HOLD.
  - If size >= 24 and the hi word is not yet sent: W_HI (DATA_IN = data[31:16]) -> C_WR -> HOLD -> C_CLR -> HOLD.
  - C_START: write CTRL = 3, baddr held at STATUS.
  - WAIT_BUSY: until rd_data[TXDONE_BIT]=1.
  - WAIT_DONE: until rd_data[TXDONE_BIT]=0.
  - C_CLR -> HOLD -> C_RD: write CTRL = 2 (READ), then HOLD.
  - Last HOLD cycle, baddr=DATA_OUT: capture rd_data into rsp_data[15:0].
  - If size >= 24: C_CLR -> C_RD -> HOLD, capture into [31:16].
  - Final C_CLR -> RSP.
- RSP: rsp_valid=1; rsp_data and rsp_err stable until rsp_ready. The cycle after acceptance: IDLE, rsp_valid=0, req_ready=1.
- HOLD counter: counts HOLD_CYC..1. HOLD_CYC=0 is treated as 1.
- Latency (HOLD_CYC=8, size<=16, ignoring SPI wait time): 45 cycles from request acceptance to rsp_valid.
- WAIT_BUSY: if TxDone is already 1 on entry, proceed to WAIT_DONE on the next cycle.

Optional Feature:
- Macro: SPI_SEQ_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in WAIT_BUSY/WAIT_DONE and clears on state entry.
  - On reaching TIMEOUT_CYC: write CTRL = 5 (RST), then CTRL = 4 (CLEAR).
  - Go to RSP with rsp_err=1 and rsp_data=0.
- Undefined: both waits are unbounded and rsp_err is tied 0.

Test Plan:
- 8-bit transfer: size=8, data=0xA5, SPI model echoes 0x3C -> DATASIZE=0x0008, DATA_IN=0x00A5, CTRL writes 1,4,3,4,2,4 in order; rsp_data=0x0000003C, rsp_err=0.
- 32-bit transfer: size=32, data=0x12345678 -> DATA_IN writes 0x5678 then 0x1234; two READ captures; rsp_data equals the model's 32-bit return.
- Backpressure: rsp_ready held low 20 cycles -> rsp_valid and rsp_data stable, req_ready=0; the second request is accepted only after the handshake.
- Reset during WAIT_DONE: rst low for 1 cycle -> bwr=0, busy=0, req_ready=1 immediately; a new request completes normally.
- Timeout (macro on, TIMEOUT_CYC=64, TxDone stuck 0) -> CTRL=5 then CTRL=4 written; rsp_err=1, rsp_data=0.
- Illegal size=12 -> DATASIZE written as 0x0008; single DATA_IN write.
